// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and frame helpers for the buffered UART transmitter.
// Build option: define UART_TX_PARITY_EN to add one parity bit to every frame.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  localparam int unsigned PARITY_BITS = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_e;
`endif

  // Line bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_bits,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_buf_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data and an occupancy count.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: UART transmitter fed by a FIFO. Frames are start, DATA_BITS data
// bits LSB first, optional parity, STOP_BITS stop bits; each bit lasts
// FREQ/RATE clocks. Queued words go out back to back with no idle gap.
// Build option: UART_TX_PARITY_EN inserts a parity bit (odd when PARITY_ODD=1).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned RATE       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned DIV        = FREQ / RATE;
  localparam int unsigned CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY_BITS, STOP_BITS);
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP  = IDX_W'(STOP_BITS - 1);

  // Elaboration-time parameter sanity checks.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
    $error("uart_tx_buf: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
    $error("uart_tx_buf: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_buf: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (PARITY_ODD > 1) begin : g_chk_parity
    $error("uart_tx_buf: PARITY_ODD must be 0 or 1");
  end
  if (DIV < 1) begin : g_chk_div
    $error("uart_tx_buf: FREQ/RATE must be at least 1");
  end

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  avail_q;
  logic                  bit_end;
  logic                  start_frame;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (i_valid),
    .wdata_i (i_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bit_end = (cnt_q == '0);

  // Next-state logic: baud countdown, bit index, shift register and FIFO pop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // avail_q lags the FIFO by one cycle, so an idle block starts a frame
        // two edges after the first write and a burst queues up meanwhile.
        start_frame = avail_q && !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = CNT_RELOAD;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = CNT_RELOAD;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (start_frame) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_rdata;
      state_d  = START;
      cnt_d    = CNT_RELOAD;
      idx_d    = '0;
`ifdef UART_TX_PARITY_EN
      par_d    = (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
    end
  end

  // Line level for the upcoming state, registered so o_tx tracks state_q.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      avail_q <= !fifo_empty;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the word in flight, captured when it leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign o_ready = !fifo_full;
  assign o_tx    = tx_q;
  assign o_busy  = (state_q != IDLE) || !fifo_empty;
  assign o_level = fifo_level;

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000: clock frequency, Hz.
REQ-002 SHALL have parameter RATE, default 115_200: baud rate, bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: TX buffer entries, power of 2, at least 2.
REQ-006 SHALL have parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even; only used under the Configuration macro.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port i_data, input, DATA_BITS: byte to send.
REQ-010 SHALL have port i_valid, input, 1: i_data is valid.
REQ-011 SHALL have port o_ready, output, 1: buffer can accept data.
REQ-012 SHALL have port o_tx, output, 1: serial line, idle high.
REQ-013 SHALL have port o_busy, output, 1: high while a frame is on the line or the buffer is non-empty.
REQ-014 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1: number of buffered entries.

Function
REQ-015 SHALL set the bit period to DIV = FREQ/RATE clocks, using truncating integer division; every line bit lasts exactly DIV cycles.
REQ-016 SHALL accept a write on any rising edge where i_valid && o_ready; o_ready = (o_level != FIFO_DEPTH), combinational from state.
REQ-017 SHALL ignore i_valid while full, with no overwrite and no level change, even if a pop happens in the same cycle.
REQ-018 SHALL support a simultaneous push and pop when not full: o_level stays unchanged and the data order is preserved.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; transitions are IDLE->START when the FIFO is non-empty, START->DATA, DATA->PARITY when parity is compiled in and otherwise DATA->STOP, PARITY->STOP, STOP->START when non-empty, and STOP->IDLE otherwise.
REQ-020 SHALL pop the FIFO on the IDLE->START or STOP->START transition and latch the word into a shift register.
REQ-021 SHALL drive the line as follows: START is 0; DATA is LSB first, DATA_BITS bits; PARITY is the parity bit; STOP is 1 for STOP_BITS*DIV cycles.
REQ-022 SHALL start a frame with latency 2: with a write accepted at edge N into an empty, idle block, o_tx falls after edge N+2.
REQ-023 SHALL send back-to-back frames with no idle gap: the next start bit follows the final stop-bit cycle immediately.
REQ-024 SHALL register o_tx, with no combinational path from any input to o_tx.
REQ-025 SHALL use a baud counter that counts DIV-1 down to 0, reloads at each bit boundary, and wraps with no drift across frames.

Reset
REQ-026 SHALL, while rst is high, force o_tx=1, o_busy=0, o_level=0, FSM=IDLE, counters=0, and FIFO pointers=0.
REQ-027 SHALL handle reset mid-frame by aborting the frame: o_tx is high after the reset edge, buffered data is discarded, and o_ready=1 on the first cycle after rst falls.

Configuration
REQ-028 SHALL, with UART_TX_PARITY_EN defined, insert one parity bit after the data bits: XOR of the data bits, inverted when PARITY_ODD=1.
REQ-029 SHALL, without UART_TX_PARITY_EN, have no PARITY state, no parity logic, and ignore PARITY_ODD.

Structure
REQ-030 SHALL place the FSM state enum and a frame-length helper function (1+DATA_BITS+parity+STOP_BITS) in shared package uart_pkg.
REQ-031 SHALL implement the buffer as sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/level); the FSM, baud counter and shift register stay in uart_tx_buf.

Verification (all with FREQ=800, RATE=100, so DIV=8)
REQ-032 SHALL cover a single-byte test: write 0x55 when idle, 8N1 -> o_tx low after edge N+2, then 1,0,1,0,1,0,1,0, then high, each 8 cycles; the frame is 80 cycles; o_busy drops after the stop bit.
REQ-033 SHALL cover a burst test: write 0x41,0x42,0x43 on consecutive cycles -> three frames with no gap (240 cycles); o_level goes 1,2,2,... then back to 0.
REQ-034 SHALL cover a full test: with FIFO_DEPTH=4, write 6 bytes back-to-back -> o_ready=0 once o_level=4; extra writes are dropped; the transmitted stream contains no data beyond the accepted 5 (1 popped plus 4 buffered).
REQ-035 SHALL cover parity under UART_TX_PARITY_EN: 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; the frame is 88 cycles.
REQ-036 SHALL cover a configuration test: DATA_BITS=7, STOP_BITS=2, data 0x7F -> 7 data bits of 1, then the line high for 16 cycles; the frame is 80 cycles without parity.
REQ-037 SHALL cover reset mid-frame: assert rst during data bit 3 -> o_tx=1, o_level=0, o_busy=0 on the next edge; no residual frame after release.
